// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// -----------------
// Scan scheduler for a multiplexed NUM_DIGITS-digit 7-segment display.
// Owns the per-digit time slot (prescaler), the slot counter, the
// BLANK/DRIVE state per slot and the frame shadow register. Presents one
// nibble per slot on digit_data (to decoder_7_seg) and a one-hot DIGIT
// enable. A producer hands over a whole frame with a load/ack handshake
// that is only honoured at the frame boundary, so a frame never tears.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, a digit i > 0 whose nibbles i..NUM_DIGITS-1 are all zero
//   keeps its enable low for its whole slot. Slot timing is unchanged.
//
// All outputs are registered. Each output register is loaded with the
// value that belongs to the *next* counter state, so DIGIT, digit_data,
// ack and frame_start line up cycle-for-cycle with prescaler/slot.

module display_scan_ctrl #(
    parameter int NUM_DIGITS = 4,     // legal 2..8
    parameter int PRESCALE   = 50000, // cycles per slot, >= 2
    parameter int BLANK      = 500    // blanking cycles per slot, < PRESCALE
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   frame,
    output logic                      ack,
    output logic [3:0]                digit_data,
    output logic [NUM_DIGITS-1:0]     DIGIT,
    output logic                      frame_start
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int SW = $clog2(NUM_DIGITS);

    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] BLANK_CNT = PW'(BLANK);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);

    // Per-slot state machine encoding
    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]                prescaler;
    logic [SW-1:0]                slot;
    logic [0:0]                   state;
    logic [NUM_DIGITS-1:0][3:0]   shadow;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic                         pre_wrap;     // last cycle of a slot
    logic                         boundary;     // last cycle of a frame
    logic                         accept;       // frame taken on this edge
    logic [PW-1:0]                prescaler_nxt;
    logic [SW-1:0]                slot_nxt;
    logic [0:0]                   state_nxt;
    logic [NUM_DIGITS-1:0][3:0]   shadow_nxt;   // shadow with frame bypass
    logic [NUM_DIGITS-1:0]        slot_onehot;
    logic [NUM_DIGITS-1:0]        lit_mask;     // digits allowed to light
    logic [NUM_DIGITS-1:0]        digit_nxt;
    logic [3:0]                   digit_data_nxt;

    // Slot/frame counters and the frame-boundary handshake decision
    // NOTE: every signal assigned in an always_comb gets a default at the
    // top of the block; a path that skips an assignment would infer a latch.
    always_comb begin
        pre_wrap      = (prescaler == PRE_LAST);
        boundary      = pre_wrap && (slot == SLOT_LAST);
        accept        = boundary && load;

        prescaler_nxt = prescaler + 1'b1;
        slot_nxt      = slot;
        if (pre_wrap) begin
            prescaler_nxt = '0;
            slot_nxt      = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
        end

        // The accepted frame is bypassed so the digit-0 slot that starts
        // right after the boundary already shows the new data.
        shadow_nxt    = accept ? frame : shadow;
    end

    // Per-slot BLANK/DRIVE state machine, evaluated for the next cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_BLANK: begin
                // With BLANK == 0 the machine only ever sits in BLANK for
                // the first cycle after reset.
                if ((prescaler_nxt == BLANK_CNT) || (BLANK_CNT == '0)) begin
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (pre_wrap && (BLANK_CNT != '0)) begin
                    state_nxt = ST_BLANK;
                end
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_nz;

    // Leading-zero suppression mask from the frame that the next slot shows
    always_comb begin
        lit_mask = '1;
        upper_nz = 1'b0;
        // Walk from the most significant digit down; a digit stays lit as
        // soon as it or any digit above it is non-zero. Digit 0 always lit.
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_nz    = upper_nz | (shadow_nxt[i] != 4'h0);
            lit_mask[i] = upper_nz;
        end
    end
`else
    // Every digit is driven during DRIVE regardless of its value
    always_comb begin
        lit_mask = '1;
    end
`endif

    // Output values for the next cycle (digit enable and nibble mux)
    always_comb begin
        slot_onehot    = NUM_DIGITS'(1) << slot_nxt;
        digit_nxt      = (state_nxt == ST_DRIVE) ? (slot_onehot & lit_mask) : '0;
        // The nibble is latched once per slot and then held, including
        // through the blanking window.
        digit_data_nxt = pre_wrap ? shadow_nxt[slot_nxt] : digit_data;
    end

    // Registered state and outputs; reset clears everything, display dark
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: the frame shadow is reset too, so the first frame after reset
    // shows zeros rather than power-up garbage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prescaler   <= '0;
            slot        <= '0;
            state       <= ST_BLANK;
            shadow      <= '0;
            digit_data  <= '0;
            DIGIT       <= '0;
            ack         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            prescaler   <= prescaler_nxt;
            slot        <= slot_nxt;
            state       <= state_nxt;
            shadow      <= shadow_nxt;
            digit_data  <= digit_data_nxt;
            DIGIT       <= digit_nxt;
            ack         <= accept;
            frame_start <= boundary;
        end
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Scan scheduler for a multiplexed N-digit 7-segment display. It owns the per-digit time slot, the inter-digit blanking window and the frame shadow register. It feeds one nibble at a time to the existing `decoder_7_seg` and drives the one-hot digit enables. Producers such as counters hand it a whole frame through a load/ack handshake; the handshake is accepted only at frame boundaries so a frame can never tear.

## Interface
- NUM_DIGITS, 4: digits scanned; legal range 2..8.
- PRESCALE, 50000: CLK cycles per digit slot; must be ≥ 2.
- BLANK, 500: cycles at the start of each slot with all digits off; must be < PRESCALE. A value of 0 means no blanking.

- CLK  in  1  system clock; all state on posedge.
- RST  in  1  asynchronous, active-high reset.
- load  in  1  frame load request; level, held until ack.
- frame  in  4*NUM_DIGITS  frame data; nibble i = digit i, and digit 0 is the least significant (units).
- ack  out  1  one-cycle pulse; frame accepted.
- digit_data  out  4  nibble for the current slot, to the decoder's D input.
- DIGIT  out  NUM_DIGITS  one-hot active-high digit enables.
- frame_start  out  1  one-cycle pulse on the first cycle of a digit-0 slot.

## Operation
- Counters:
  - prescaler runs 0..PRESCALE-1 and wraps.
  - slot runs 0..NUM_DIGITS-1 and advances when prescaler wraps; it wraps from NUM_DIGITS-1 to 0.
- Per-slot state machine:
  - BLANK while prescaler < BLANK; DIGIT = 0.
  - DRIVE while prescaler ≥ BLANK; DIGIT = 1 << slot.
  - Transitions: BLANK→DRIVE at prescaler == BLANK; DRIVE→BLANK at the wrap.
- digit_data loads shadow[slot] on the edge entering prescaler == 0. It is stable for the whole slot, including BLANK.
- Boundary cycle: slot == NUM_DIGITS-1 and prescaler == PRESCALE-1.
- Load handshake:
  - If load is high in the boundary cycle, shadow ← frame on that edge.
  - ack pulses in the following cycle.
  - digit_data for that digit-0 slot uses the new frame (frame is bypassed into the mux).
- load high outside the boundary cycle:
  - Has no effect, but the request stays pending while load is held.
  - If load is dropped before a boundary, nothing happens: no ack and the shadow is unchanged.
- frame_start pulses in the cycle after every boundary, coincident with any ack.
- A producer must deassert load in the ack cycle. If load is still high at the next boundary, that is a new request.
- Reset values:
  - prescaler, slot, shadow, digit_data, DIGIT, ack and frame_start all 0.
  - State is BLANK.
  - Reset is asynchronous: DIGIT goes to 0 immediately, even mid-DRIVE.
  - After release, the first slot is slot 0 and no frame_start is issued until the first boundary.

## Timing
- Frame period is NUM_DIGITS*PRESCALE cycles; each digit is lit for PRESCALE-BLANK cycles.
- DIGIT, digit_data, ack and frame_start are all registered outputs with no combinational input→output path.
- Load latency is 1 to NUM_DIGITS*PRESCALE cycles from load assertion to ack.
- Simultaneous load and boundary: accepted in that cycle; ack follows 1 cycle later.
- BLANK = 0: DIGIT is asserted from prescaler == 0. The BLANK state is never entered except at reset, and it exits on the first cycle.

## Configuration
- LEADING_ZERO_BLANK_EN, when defined:
  - A digit i > 0 is suppressed if nibbles i..NUM_DIGITS-1 of the shadow are all zero.
  - A suppressed digit keeps DIGIT at 0 for its entire slot.
  - Slot timing is unchanged, so brightness of the other digits stays constant.
  - digit_data is still presented.
  - Digit 0 is never suppressed.
- When undefined, all digits are driven in DRIVE regardless of value.

## Test plan
All scenarios use PRESCALE=8, BLANK=2, NUM_DIGITS=4.
- Reset: assert RST mid-DRIVE of slot 2 → DIGIT=0, digit_data=0, ack=0 in the same cycle. After release → cycles 0-1 DIGIT=0, cycle 2 DIGIT=4'b0001.
- Scan order: load frame 16'h4321 → per slot 2 blank cycles then 6 lit. DIGIT goes 0001→0010→0100→1000 with digit_data 1,2,3,4. Period 32 cycles; frame_start every 32 cycles.
- Mid-frame load: frame 16'h9876 with load raised during slot 1 and held → old digits shown through slot 3. ack and frame_start coincide after the boundary; next digit_data = 6.
- Load at boundary: load high only in the boundary cycle → ack next cycle, and digit_data shows the new digit 0 immediately.
- Dropped load: load pulsed for 3 cycles in slot 1 → no ack, and the displayed frame is unchanged over the next 2 frames.
- Macro: frame 16'h0050 with LEADING_ZERO_BLANK_EN → only DIGIT bits 0 and 1 ever assert. Frame 16'h0000 → only bit 0 asserts. Without the macro → all four bits assert.
